// File: rtl/ahb_reg_arbiter.sv
// Two-requester, single-transfer AHB-Lite master for the 0x8xxx_xxxx register block.
// Round-robin grant in IDLE, then one ADDR phase and one DATA phase per command.
module ahb_reg_arbiter #(
  parameter int unsigned TIMEOUT     = 16,
  parameter logic [3:0]  BASE_NIBBLE = 4'h8
) (
  input  logic        hclk,
  input  logic        hresetn,

  input  logic        req0_valid,
  input  logic        req0_write,
  input  logic [15:0] req0_addr,
  input  logic [31:0] req0_wdata,
  output logic        req0_ready,
  output logic        req0_done,
  output logic [31:0] req0_rdata,
  output logic        req0_err,

  input  logic        req1_valid,
  input  logic        req1_write,
  input  logic [15:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        req1_ready,
  output logic        req1_done,
  output logic [31:0] req1_rdata,
  output logic        req1_err,

  output logic [31:0] haddr,
  output logic [1:0]  htrans,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [2:0]  hburst,
  output logic [31:0] hwdata,
  input  logic [31:0] hrdata,
  input  logic        hready,
  input  logic [1:0]  hresp
);

  typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

  // Abort fires on the hready-low cycle that would make the count reach TIMEOUT.
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic        write_q, write_d;
  logic [13:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  cnt_q, cnt_d, cnt_inc;
  logic [1:0]  ready_q, ready_d;
  logic [1:0]  done_q, done_d;
  logic [1:0]  err_q, err_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic        gnt;
  logic        unused_bits;

  assign unused_bits = ^{req0_addr[1:0], req1_addr[1:0], hresp[1]};
  assign cnt_inc     = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    write_d  = write_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    ready_d  = 2'b00;
    done_d   = 2'b00;
    err_d    = err_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    gnt      = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = 8'd0;
        if (req0_valid || req1_valid) begin
          gnt          = (req0_valid && req1_valid) ? ~last_q : req1_valid;
          owner_d      = gnt;
          last_d       = gnt;
          write_d      = gnt ? req1_write : req0_write;
          addr_d       = gnt ? req1_addr[15:2] : req0_addr[15:2];
          wdata_d      = gnt ? req1_wdata : req0_wdata;
          ready_d[gnt] = 1'b1;
          state_d      = StAddr;
        end
      end

      StAddr: begin
        if (hready) begin
          state_d = StData;
          cnt_d   = 8'd0;
        end else if (cnt_q == TimeoutLast) begin
          done_d[owner_q] = 1'b1;
          err_d[owner_q]  = 1'b1;
          cnt_d           = 8'd0;
          state_d         = StIdle;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      StData: begin
        if (hready) begin
          done_d[owner_q] = 1'b1;
          err_d[owner_q]  = hresp[0];
          if (!write_q) begin
            if (owner_q) rdata1_d = hrdata;
            else         rdata0_d = hrdata;
          end
          cnt_d   = 8'd0;
          state_d = StIdle;
        end else if (cnt_q == TimeoutLast) begin
          done_d[owner_q] = 1'b1;
          err_d[owner_q]  = 1'b1;
          cnt_d           = 8'd0;
          state_d         = StIdle;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state_q  <= StIdle;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      ready_q  <= '0;
      done_q   <= '0;
      err_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_comb begin
    htrans = (state_q == StAddr) ? 2'b10 : 2'b00;
    haddr  = (state_q == StAddr) ? {BASE_NIBBLE, 12'h000, addr_q, 2'b00} : 32'h0;
    hwrite = (state_q == StAddr) && write_q;
    hwdata = ((state_q == StData) && write_q) ? wdata_q : 32'h0;
  end

  assign hsize      = 3'b010;
  assign hburst     = 3'b000;
  assign req0_ready = ready_q[0];
  assign req1_ready = ready_q[1];
  assign req0_done  = done_q[0];
  assign req1_done  = done_q[1];
  assign req0_err   = err_q[0];
  assign req1_err   = err_q[1];
  assign req0_rdata = rdata0_q;
  assign req1_rdata = rdata1_q;

endmodule

// File: tb/tb_ahb_reg_arbiter.sv
// Scoreboard bench for ahb_reg_arbiter: a small word-memory slave, per-transfer
// expectations queued at issue time and retired on each done pulse.
module tb_ahb_reg_arbiter;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        req0_valid = 1'b0, req0_write = 1'b0;
  logic [15:0] req0_addr = '0;
  logic [31:0] req0_wdata = '0;
  logic        req0_ready, req0_done, req0_err;
  logic [31:0] req0_rdata;
  logic        req1_valid = 1'b0, req1_write = 1'b0;
  logic [15:0] req1_addr = '0;
  logic [31:0] req1_wdata = '0;
  logic        req1_ready, req1_done, req1_err;
  logic [31:0] req1_rdata;
  logic [31:0] haddr, hwdata, hrdata;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize, hburst;
  logic        hready = 1'b1;
  logic [1:0]  hresp = 2'b00;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  typedef struct {
    int unsigned owner;
    logic        err;
    logic        chk_rd;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  int unsigned grant_log[$];

  always #5 hclk = ~hclk;

  ahb_reg_arbiter #(
    .TIMEOUT    (16),
    .BASE_NIBBLE(4'h8)
  ) dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .req0_valid(req0_valid),
    .req0_write(req0_write),
    .req0_addr (req0_addr),
    .req0_wdata(req0_wdata),
    .req0_ready(req0_ready),
    .req0_done (req0_done),
    .req0_rdata(req0_rdata),
    .req0_err  (req0_err),
    .req1_valid(req1_valid),
    .req1_write(req1_write),
    .req1_addr (req1_addr),
    .req1_wdata(req1_wdata),
    .req1_ready(req1_ready),
    .req1_done (req1_done),
    .req1_rdata(req1_rdata),
    .req1_err  (req1_err),
    .haddr     (haddr),
    .htrans    (htrans),
    .hwrite    (hwrite),
    .hsize     (hsize),
    .hburst    (hburst),
    .hwdata    (hwdata),
    .hrdata    (hrdata),
    .hready    (hready),
    .hresp     (hresp)
  );

  // Slave: captures the address phase, completes the data phase from mem.
  logic [31:0] mem [0:255];
  logic        dph_valid = 1'b0;
  logic        dph_write = 1'b0;
  logic [7:0]  dph_idx = '0;

  assign hrdata = dph_valid ? mem[dph_idx] : 32'h0;

  initial for (int i = 0; i < 256; i++) mem[i] = 32'h0;

  always @(posedge hclk) begin
    if (dph_valid && hready) begin
      if (dph_write) mem[dph_idx] <= hwdata;
      dph_valid <= 1'b0;
    end
    if (htrans == 2'b10 && hready) begin
      dph_valid <= 1'b1;
      dph_idx   <= haddr[9:2];
      dph_write <= hwrite;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Retire one expectation per done pulse.
  always @(negedge hclk) begin
    if (req0_ready) grant_log.push_back(0);
    if (req1_ready) grant_log.push_back(1);
    if (req0_done || req1_done) begin
      check("done_exclusive", 32'(req0_done & req1_done), 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        int unsigned own;
        e   = sb.pop_front();
        own = req1_done ? 1 : 0;
        check("done_owner", own, e.owner);
        check("done_err", 32'(own ? req1_err : req0_err), 32'(e.err));
        if (e.chk_rd) check("done_rdata", own ? req1_rdata : req0_rdata, e.rdata);
      end
    end
  end

  function automatic logic [31:0] bus_addr(input logic [15:0] a);
    return {4'h8, 12'h000, a[15:2], 2'b00};
  endfunction

  // Drives one command, waits for ready, checks the ADDR-phase bus, drops valid.
  task automatic issue(input int unsigned n, input logic wr, input logic [15:0] a,
                       input logic [31:0] d, input logic exp_err, input logic chk_rd,
                       input logic [31:0] exp_rd);
    exp_t e;
    bit   got = 0;
    e.owner = n; e.err = exp_err; e.chk_rd = chk_rd; e.rdata = exp_rd;
    sb.push_back(e);
    @(negedge hclk);
    if (n == 0) begin
      req0_valid = 1'b1; req0_write = wr; req0_addr = a; req0_wdata = d;
    end else begin
      req1_valid = 1'b1; req1_write = wr; req1_addr = a; req1_wdata = d;
    end
    for (int i = 0; i < 20; i++) begin
      @(posedge hclk); #1;
      if ((n == 0 && req0_ready) || (n == 1 && req1_ready)) begin
        got = 1;
        break;
      end
    end
    if (!got) check("ready_wait", 32'd0, 32'd1);
    check("addr_htrans", 32'(htrans), 32'h2);
    check("addr_haddr", haddr, bus_addr(a));
    check("addr_hwrite", 32'(hwrite), 32'(wr));
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge hclk);
    check("sb_drain", sb.size(), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_bus"}, {htrans, hwrite, 29'h0}, 32'h0);
    check({tag, "_haddr"}, haddr, 32'h0);
    check({tag, "_hwdata"}, hwdata, 32'h0);
    check({tag, "_flags"}, 32'({req0_ready, req1_ready, req0_done, req1_done,
                                req0_err, req1_err}), 32'h0);
    check({tag, "_rdata"}, req0_rdata | req1_rdata, 32'h0);
  endtask

  initial begin
    int c0, c1;
    // Reset
    repeat (2) @(posedge hclk);
    #1 check_reset_outputs("reset");
    check("hsize", 32'(hsize), 32'h2);
    check("hburst", 32'(hburst), 32'h0);
    @(negedge hclk) hresetn = 1'b1;

    // Basic write with exact latency
    issue(0, 1'b1, 16'h0000, 32'hA5A5_00F0, 1'b0, 1'b0, 32'h0);
    @(posedge hclk); #1;
    check("w_data_htrans", 32'(htrans), 32'h0);
    check("w_hwdata", hwdata, 32'hA5A5_00F0);
    check("w_early_done", 32'(req0_done), 32'd0);
    @(posedge hclk); #1;
    check("w_done_lat", 32'(req0_done), 32'd1);
    wait_drain();

    // Write then read back
    issue(0, 1'b1, 16'h0004, 32'h1234_5678, 1'b0, 1'b0, 32'h0);
    wait_drain();
    issue(0, 1'b0, 16'h0007, 32'h0, 1'b0, 1'b1, 32'h1234_5678);
    wait_drain();

    // Three DATA wait states on a write
    issue(0, 1'b1, 16'h0008, 32'hCAFE_0001, 1'b0, 1'b0, 32'h0);
    @(posedge hclk); #1;
    hready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("ws_hwdata", hwdata, 32'hCAFE_0001);
      check("ws_no_done", 32'(req0_done), 32'd0);
      @(posedge hclk); #1;
    end
    hready = 1'b1;
    check("ws_hwdata_rise", hwdata, 32'hCAFE_0001);
    @(posedge hclk); #1;
    check("ws_done", 32'(req0_done), 32'd1);
    wait_drain();
    issue(1, 1'b0, 16'h0008, 32'h0, 1'b0, 1'b1, 32'hCAFE_0001);
    wait_drain();

    // ADDR timeout; rdata of requester 1 must stay at its last read value
    hready = 1'b0;
    issue(1, 1'b0, 16'h000C, 32'h0, 1'b1, 1'b1, 32'hCAFE_0001);
    for (int i = 1; i < 16; i++) begin
      @(posedge hclk); #1;
      check("to_no_done", 32'(req1_done), 32'd0);
    end
    @(posedge hclk); #1;
    check("to_done", 32'(req1_done), 32'd1);
    check("to_htrans", 32'(htrans), 32'h0);
    hready = 1'b1;
    wait_drain();
    issue(0, 1'b0, 16'h0004, 32'h0, 1'b0, 1'b1, 32'h1234_5678);
    wait_drain();

    // Error response on a read still captures hrdata
    issue(1, 1'b0, 16'h0004, 32'h0, 1'b1, 1'b1, 32'h1234_5678);
    hresp = 2'b01;
    wait_drain();
    hresp = 2'b00;

    // Reset during DATA
    issue(0, 1'b1, 16'h0010, 32'h5555_AAAA, 1'b0, 1'b0, 32'h0);
    @(posedge hclk); #1;
    check("rst_in_data", hwdata, 32'h5555_AAAA);
    hresetn = 1'b0;
    sb.delete();
    @(posedge hclk); #1;
    check_reset_outputs("rst_data");
    hresetn = 1'b1;
    repeat (3) begin
      @(posedge hclk); #1;
      check("rst_no_done", 32'(req0_done | req1_done), 32'd0);
    end

    // Both requesters held valid: strict alternation starting with 0
    grant_log.delete();
    for (int i = 0; i < 6; i++) begin
      exp_t e;
      e.owner = i % 2; e.err = 1'b0; e.chk_rd = 1'b0; e.rdata = 32'h0;
      sb.push_back(e);
    end
    c0 = 0; c1 = 0;
    @(negedge hclk);
    req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 16'h0020; req0_wdata = 32'h100;
    req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 16'h0024; req1_wdata = 32'h200;
    for (int i = 0; i < 100 && sb.size() != 0; i++) begin
      @(negedge hclk);
      if (req0_ready) begin
        c0++;
        req0_wdata = 32'h100 + 32'(c0);
        if (c0 == 3) req0_valid = 1'b0;
      end
      if (req1_ready) begin
        c1++;
        req1_wdata = 32'h200 + 32'(c1);
        if (c1 == 3) req1_valid = 1'b0;
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_drain();
    check("rr_count", grant_log.size(), 32'd6);
    for (int i = 0; i < 6 && i < grant_log.size(); i++)
      check("rr_order", grant_log[i], 32'(i % 2));
    check("rr_last_mem1", mem[9], 32'h202);

    repeat (2) @(posedge hclk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_reg_arbiter.md
Name: ahb_reg_arbiter

Overview:
- Single-transfer AHB-Lite master that shares one AHB register slave between two local requesters (for example, CPU-side glue and a DMA/test sequencer).
- Arbitrates requests round-robin and sequences each accepted command through the AHB address and data phases.
- Returns read data and completion/error status to the owning requester.
- Sits between the requesters and the bus slave ports (hsel/haddr/htrans/...) of the 0x8xxx_xxxx register block.

Parameters:
TIMEOUT, 16, consecutive hready-low cycles in ADDR or DATA before the transfer is aborted with error (valid range 2..255).
BASE_NIBBLE, 4'h8, value forced onto haddr[31:28] for every transfer.

Ports:
hclk  in  1  bus clock; all logic on rising edge
hresetn  in  1  reset, synchronous, active-low
reqN_valid  in  1  (N=0,1) command request; held until reqN_ready
reqN_write  in  1  1=write, 0=read
reqN_addr  in  16  register byte offset; [1:0] ignored
reqN_wdata  in  32  write data
reqN_ready  out  1  one-cycle pulse: command accepted
reqN_done  out  1  one-cycle pulse: transfer finished
reqN_rdata  out  32  read data, valid with reqN_done, held until the next done to N
reqN_err  out  1  valid with reqN_done: hresp error or timeout
haddr  out  32  {BASE_NIBBLE, 12'h000, addr[15:2], 2'b00}
htrans  out  2  2'b10 NONSEQ in ADDR, else 2'b00 IDLE
hwrite  out  1  latched write flag in ADDR, else 0
hsize  out  3  constant 3'b010 (word)
hburst  out  3  constant 3'b000 (SINGLE)
hwdata  out  32  latched wdata during DATA, else 0
hrdata  in  32  slave read data
hready  in  1  slave ready
hresp  in  2  slave response; bit0=ERROR

Behaviour:
- States: IDLE, ADDR, DATA.
- Reset (hresetn low at a clock edge), regardless of state:
  - state=IDLE, htrans=IDLE, haddr/hwrite/hwdata=0.
  - All ready/done/err=0, all rdata=0.
  - last_grant=1, so requester 0 wins first; timeout counter=0.
- IDLE:
  - If exactly one reqN_valid, grant N.
  - If both valid, grant the one not equal to last_grant.
  - On grant: latch write/addr/wdata, pulse reqN_ready, set last_grant=N, go to ADDR.
  - No request: remain in IDLE with htrans=IDLE.
- ADDR:
  - Drive NONSEQ, haddr and hwrite from the latched command.
  - If hready=1, go to DATA and clear the counter; else increment the counter.
- DATA:
  - Drive hwdata (write) and htrans=IDLE.
  - When hready=1:
    - pulse reqN_done;
    - reqN_err = hresp[0];
    - for reads, capture hrdata into reqN_rdata (also on error);
    - go to IDLE.
  - If hready=0, increment the counter.
- Timeout: when the counter reaches TIMEOUT (TIMEOUT consecutive hready-low cycles in the current phase):
  - pulse done with err=1; rdata unchanged;
  - go to IDLE with htrans=IDLE.
- Counter: 8 bit, saturating; cleared on every phase change.
- Latency with hready always high: valid sampled at edge k gives ready at k+1, ADDR at k+1, DATA at k+2, done at k+3.
- Minimum 3 cycles per transfer; no address/data pipelining across transfers.
- Grant is only re-evaluated in IDLE. A request that appears or drops during ADDR/DATA does not affect the current transfer.
- A requester must not drop valid before ready. If it does in IDLE, the request is simply not granted.
- Only one of req0_done/req1_done is asserted in any cycle; ready and done never both high for the same requester in one cycle.
- Writes: the slave samples hwdata in DATA, so hwdata stays stable for all of DATA including wait states.

Test Plan:
- Req0 write addr 0x0000, wdata 0xA5A5_00F0, hready=1 → ready@+1; haddr=0x8000_0000/NONSEQ/hwrite=1 @+1; hwdata=0xA5A5_00F0 @+2; done0@+3, err0=0.
- Req0 read addr 0x0004 after a write of 0x1234_5678 to 0x0004 → done0 with rdata0=0x1234_5678, err0=0; haddr=0x8000_0004.
- Req0 and req1 held valid continuously, 6 transfers → grant order 0,1,0,1,0,1. Each done is routed only to its owner; never simultaneous.
- Slave holds hready low 3 cycles in DATA of a write → hwdata stable throughout, done exactly 1 cycle after hready rises, err=0.
- TIMEOUT=16, hready stuck low in ADDR → done with err=1 on the 16th low cycle, htrans returns to IDLE, next request serviced normally.
- hresp=2'b01 on a read; separately, hresetn low in DATA → first case: done with err=1 and rdata=hrdata. Second case: all outputs 0 next cycle, no done pulse, requester 0 wins the next arbitration.
